// File: rtl/vga_scan_pkg.sv
// Shared definitions for the VGA scan tracker: default active-area geometry,
// linear address width and the commit handshake state encoding.
package vga_scan_pkg;

  localparam int H_ACTIVE_DFLT = 640;
  localparam int V_ACTIVE_DFLT = 480;
  localparam int ADDR_W        = 19;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    ACK     = 2'd2,
    DONE    = 2'd3
  } commit_state_e;

endpackage

// File: rtl/vga_commit_fsm.sv
// Commit handshake FSM and shadow state register. A request is held in
// PENDING until vertical blank; at most one capture happens per blank
// interval (done_this_blank), so the renderer never sees a mid-frame change.
//
// Handshake: commit_req is a level request that must stay high, with
// state_word stable, until commit_ack has been seen; commit_ack pulses for
// one cycle the cycle after the capture edge. Dropping the request before
// capture abandons it without touching shadow_state. After the ack the FSM
// waits in DONE until the request is released.
module vga_commit_fsm
  import vga_scan_pkg::*;
#(
  parameter int STATE_W = 32
) (
  input  logic               iVGA_CLK,
  input  logic               iRST_n,
  input  logic               vblank,
  input  logic               blank_fall,
  input  logic               commit_req,
  input  logic [STATE_W-1:0] state_word,
  output logic               commit_ack,
  output logic [STATE_W-1:0] shadow_state,
  output commit_state_e      fsm_state
);

  commit_state_e state_q, state_nxt;
  logic          capture;
  logic          done_this_blank;

  // State register
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) state_q <= IDLE;
    else         state_q <= state_nxt;
  end

  // Next-state decode; ack is a Moore output of the ACK state
  always_comb begin
    state_nxt  = state_q;
    capture    = 1'b0;
    commit_ack = 1'b0;
    case (state_q)
      IDLE:    if (commit_req) state_nxt = PENDING;
      PENDING: begin
        if (!commit_req) begin
          state_nxt = IDLE;
        end else if (vblank && !done_this_blank) begin
          state_nxt = ACK;
          capture   = 1'b1;
        end
      end
      ACK: begin
        commit_ack = 1'b1;
        state_nxt  = DONE;
      end
      DONE:    if (!commit_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shadow register and one-commit-per-blank flag
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      shadow_state    <= '0;
      done_this_blank <= 1'b0;
    end else if (capture) begin
      shadow_state    <= state_word;
      done_this_blank <= 1'b1;
    end else if (blank_fall) begin
      done_this_blank <= 1'b0;
    end
  end

  assign fsm_state = state_q;

endmodule

// File: rtl/vga_scan_tracker.sv
// Scan-position tracker: registered pixel coordinates, linear address,
// vertical blank, frame start pulse / frame counter, and the frame-synchronous
// game-state commit port. Frame counter and frame start logic are built only
// when SCAN_TRACKER_FRAMECNT_EN is defined; otherwise both read constant 0.
module vga_scan_tracker
  import vga_scan_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DFLT,
  parameter int V_ACTIVE = V_ACTIVE_DFLT,
  parameter int STATE_W  = 32
) (
  input  logic               iVGA_CLK,
  input  logic               iRST_n,
  input  logic               iBLANK_n,
  input  logic               iHS,
  input  logic               iVS,
  input  logic               iCommitReq,
  input  logic [STATE_W-1:0] iState,
  output logic [9:0]         oX,
  output logic [8:0]         oY,
  output logic [ADDR_W-1:0]  oADDR,
  output logic               oVBlank,
  output logic               oFrameStart,
  output logic [15:0]        oFrameCount,
  output logic               oCommitAck,
  output logic [STATE_W-1:0] oState,
  output commit_state_e      oCommitState
);

  localparam int                LINE_W   = $clog2(V_ACTIVE + 1);
  localparam logic [9:0]        X_MAX    = 10'(H_ACTIVE - 1);
  localparam logic [8:0]        Y_MAX    = 9'(V_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [LINE_W-1:0] L_END    = LINE_W'(V_ACTIVE);

  logic              blank_d;
  logic              vblank_q;
  logic              frame_rst;
  logic              eol;
  logic              blank_fall;
  logic [LINE_W-1:0] line_cnt;
  logic [LINE_W-1:0] line_nxt;

  assign frame_rst = ~iVS & ~iHS;
  assign eol       = blank_d & ~iBLANK_n;
  assign line_nxt  = line_cnt + LINE_W'(1);

  // Pixel / line counters; frame reset overrides counting
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      blank_d  <= 1'b0;
      oX       <= '0;
      oY       <= '0;
      oADDR    <= '0;
      line_cnt <= '0;
    end else begin
      blank_d <= iBLANK_n;
      if (frame_rst) begin
        oX       <= '0;
        oY       <= '0;
        oADDR    <= '0;
        line_cnt <= '0;
      end else if (iBLANK_n) begin
        if (oX != X_MAX)       oX    <= oX + 10'd1;
        if (oADDR != ADDR_MAX) oADDR <= oADDR + ADDR_W'(1);
      end else if (eol) begin
        oX <= '0;
        if (line_cnt != L_END) begin
          line_cnt <= line_nxt;
          oY       <= (line_nxt == L_END) ? Y_MAX : 9'(line_nxt);
        end
      end
    end
  end

  // Blank flag: set once all active lines are done, cleared by the next visible pixel
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n)                vblank_q <= 1'b1;
    else if (iBLANK_n)          vblank_q <= 1'b0;
    else if (line_cnt == L_END) vblank_q <= 1'b1;
  end

  // The first visible pixel of a frame already reads oVBlank=0; during reset
  // the flag shows its reset value whatever the blank input does.
  assign oVBlank    = vblank_q & ~(iBLANK_n & iRST_n);
  assign blank_fall = vblank_q & iBLANK_n;

`ifdef SCAN_TRACKER_FRAMECNT_EN
  logic vs_d;

  // Falling-edge detect of iVS and frames-since-reset counter
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      vs_d        <= 1'b1;
      oFrameStart <= 1'b0;
      oFrameCount <= '0;
    end else begin
      vs_d        <= iVS;
      oFrameStart <= vs_d & ~iVS;
      if (oFrameStart) oFrameCount <= oFrameCount + 16'd1;
    end
  end
`else
  assign oFrameStart = 1'b0;
  assign oFrameCount = '0;
`endif

  vga_commit_fsm #(
    .STATE_W (STATE_W)
  ) u_commit (
    .iVGA_CLK     (iVGA_CLK),
    .iRST_n       (iRST_n),
    .vblank       (oVBlank),
    .blank_fall   (blank_fall),
    .commit_req   (iCommitReq),
    .state_word   (iState),
    .commit_ack   (oCommitAck),
    .shadow_state (oState),
    .fsm_state    (oCommitState)
  );

endmodule

// File: tb/tb_vga_scan_tracker.sv
// Bench for vga_scan_tracker on a reduced 8x4 active area. Drivers push the
// expected pixel tuple, commit word and frame-start count into queues; a
// negedge monitor pops and compares whenever the DUT presents a visible
// pixel, a commit ack or a frame start pulse.
module tb_vga_scan_tracker;
  import vga_scan_pkg::*;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int SW = 32;

  logic              iVGA_CLK = 1'b0;
  logic              iRST_n;
  logic              iBLANK_n;
  logic              iHS;
  logic              iVS;
  logic              iCommitReq;
  logic [SW-1:0]     iState;
  logic [9:0]        oX;
  logic [8:0]        oY;
  logic [ADDR_W-1:0] oADDR;
  logic              oVBlank;
  logic              oFrameStart;
  logic [15:0]       oFrameCount;
  logic              oCommitAck;
  logic [SW-1:0]     oState;
  commit_state_e     oCommitState;

  vga_scan_tracker #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .STATE_W  (SW)
  ) dut (
    .iVGA_CLK     (iVGA_CLK),
    .iRST_n       (iRST_n),
    .iBLANK_n     (iBLANK_n),
    .iHS          (iHS),
    .iVS          (iVS),
    .iCommitReq   (iCommitReq),
    .iState       (iState),
    .oX           (oX),
    .oY           (oY),
    .oADDR        (oADDR),
    .oVBlank      (oVBlank),
    .oFrameStart  (oFrameStart),
    .oFrameCount  (oFrameCount),
    .oCommitAck   (oCommitAck),
    .oState       (oState),
    .oCommitState (oCommitState)
  );

  // Clock
  always #5 iVGA_CLK = ~iVGA_CLK;

  // Scoreboard queues: pixel = {vblank, x, y, addr}
  logic [38:0]   pix_exp_q[$];
  logic [SW-1:0] ack_exp_q[$];
  logic [15:0]   fs_exp_q[$];

  int vec_cnt = 0;
  int err_cnt = 0;
  int frames  = 0;
  int pix     = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge iVGA_CLK) begin
    if (iRST_n === 1'b1) begin
      if (iBLANK_n === 1'b1) begin
        if (pix_exp_q.size() == 0) chk("pixel_unexpected", 64'd1, 64'd0);
        else chk("pixel", {oVBlank, oX, oY, oADDR}, pix_exp_q.pop_front());
      end
      if (oCommitAck === 1'b1) begin
        if (ack_exp_q.size() == 0) chk("ack_unexpected", 64'd1, 64'd0);
        else chk("ack_state", oState, ack_exp_q.pop_front());
      end
      if (oFrameStart === 1'b1) begin
        if (fs_exp_q.size() == 0) chk("frame_start_unexpected", 64'd1, 64'd0);
        else chk("frame_start_count", oFrameCount, fs_exp_q.pop_front());
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge iVGA_CLK);
    #1;
  endtask

  task automatic idle(input int n);
    iBLANK_n = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic vsync_pulse();
    iBLANK_n = 1'b0;
    iVS = 1'b0;
    iHS = 1'b0;
`ifdef SCAN_TRACKER_FRAMECNT_EN
    fs_exp_q.push_back(16'(frames));
`endif
    frames++;
    tick();
    tick();
    iVS = 1'b1;
    iHS = 1'b1;
    tick();
    tick();
    pix = 0;
  endtask

  // One line of npix visible pixels followed by a 3-cycle horizontal blank
  task automatic run_line(input int y, input int npix);
    for (int c = 0; c < npix; c++) begin
      iBLANK_n = 1'b1;
      pix_exp_q.push_back({1'b0, 10'((c < H) ? c : H - 1), 9'(y),
                           19'((pix < H * V) ? pix : H * V - 1)});
      pix++;
      tick();
    end
    iBLANK_n = 1'b0;
    tick();
    iHS = 1'b0;
    tick();
    iHS = 1'b1;
    tick();
  endtask

  // Stimulus
  initial begin
    iRST_n     = 1'b0;
    iBLANK_n   = 1'b0;
    iHS        = 1'b1;
    iVS        = 1'b1;
    iCommitReq = 1'b0;
    iState     = '0;
    tick(); tick(); tick();
    chk("rst_x", oX, 0);
    chk("rst_y", oY, 0);
    chk("rst_addr", oADDR, 0);
    chk("rst_vblank", oVBlank, 1);
    chk("rst_frame_start", oFrameStart, 0);
    chk("rst_frame_count", oFrameCount, 0);
    chk("rst_ack", oCommitAck, 0);
    chk("rst_state", oState, 0);
    iRST_n = 1'b1;
    tick();

    // Frame A: request raised mid-frame, committed in the following blank
    vsync_pulse();
    run_line(0, H);
    chk("vblank_active", oVBlank, 0);
    iCommitReq = 1'b1;
    iState     = 32'hDEADBEEF;
    ack_exp_q.push_back(32'hDEADBEEF);
    run_line(1, H);
    run_line(2, H);
    chk("state_hold_midframe", oState, 0);
    run_line(3, H);
    chk("vblank_set", oVBlank, 1);
    idle(2);
    iCommitReq = 1'b0;
    idle(2);
    chk("fsm_idle_after_release", oCommitState, IDLE);
    // Second request in the same blank must wait for the next one
    iCommitReq = 1'b1;
    iState     = 32'h12345678;
    ack_exp_q.push_back(32'h12345678);
    idle(4);
    chk("second_req_waits", oCommitState, PENDING);
    chk("state_after_first_commit", oState, 32'hDEADBEEF);

    // Frame B: pending request commits at this frame's blank
    vsync_pulse();
    for (int y = 0; y < V; y++) run_line(y, H);
    idle(2);
    iCommitReq = 1'b0;
    idle(2);
    chk("state_after_second_commit", oState, 32'h12345678);

    // Frame C: request dropped in PENDING; last line overruns to test saturation
    vsync_pulse();
    run_line(0, H);
    iCommitReq = 1'b1;
    iState     = 32'hCAFEF00D;
    run_line(1, H);
    iCommitReq = 1'b0;
    run_line(2, H);
    chk("fsm_idle_after_drop", oCommitState, IDLE);
    run_line(3, H + 2);
    idle(6);
    chk("state_no_capture", oState, 32'h12345678);
`ifdef SCAN_TRACKER_FRAMECNT_EN
    chk("frame_count", oFrameCount, 16'(frames));
`else
    chk("frame_count", oFrameCount, 0);
`endif

    // Frame D: asynchronous reset mid-line with a commit in flight
    vsync_pulse();
    iCommitReq = 1'b1;
    iState     = 32'hA5A5A5A5;
    for (int c = 0; c < 3; c++) begin
      iBLANK_n = 1'b1;
      pix_exp_q.push_back({1'b0, 10'(c), 9'd0, 19'(c)});
      tick();
    end
    iRST_n = 1'b0;
    #1;
    chk("mid_rst_x", oX, 0);
    chk("mid_rst_y", oY, 0);
    chk("mid_rst_addr", oADDR, 0);
    chk("mid_rst_vblank", oVBlank, 1);
    chk("mid_rst_frame_start", oFrameStart, 0);
    chk("mid_rst_frame_count", oFrameCount, 0);
    chk("mid_rst_ack", oCommitAck, 0);
    chk("mid_rst_state", oState, 0);
    chk("mid_rst_fsm", oCommitState, IDLE);
    iCommitReq = 1'b0;
    iBLANK_n   = 1'b0;
    tick();
    tick();
    iRST_n = 1'b1;
    idle(4);
    chk("state_after_reset", oState, 0);

    chk("pixel_queue_drained", pix_exp_q.size(), 0);
    chk("ack_queue_drained", ack_exp_q.size(), 0);
    chk("frame_start_queue_drained", fs_exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/vga_scan_tracker.md
# vga_scan_tracker

Scan-position tracker and frame-synchronous state latch placed between the video sync generator and the game render controller. It turns the raw blank/HS/VS stream into registered pixel coordinates, a linear pixel address, vertical-blank and frame-start indications, and a frame counter. It also gives game logic a request/acknowledge port. Game state is committed into a shadow register only during vertical blank, so the renderer never sees a mid-frame update.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- STATE_W, 32, width of committed game-state word

Ports:
- iVGA_CLK  in  1  pixel clock; all logic on rising edge
- iRST_n  in  1  reset, asynchronous, active-low
- iBLANK_n  in  1  high during visible pixel (sync-generator timing)
- iHS  in  1  horizontal sync, active-low
- iVS  in  1  vertical sync, active-low
- iCommitReq  in  1  game logic requests state commit
- iState  in  STATE_W  state word; must be stable while iCommitReq=1
- oX  out  10  column of current pixel
- oY  out  9  row of current pixel
- oADDR  out  19  linear index oY*H_ACTIVE+oX
- oVBlank  out  1  vertical blank interval
- oFrameStart  out  1  one-cycle pulse at start of each frame
- oFrameCount  out  16  frames since reset
- oCommitAck  out  1  one-cycle commit acknowledge
- oState  out  STATE_W  committed shadow state for the renderer

## Operation
- Reset values: oX=0, oY=0, oADDR=0, oVBlank=1, oFrameStart=0, oFrameCount=0, oCommitAck=0, oState=0, FSM=IDLE.
- Pixel counting:
  - Each cycle with iBLANK_n=1 presents the current oX/oY/oADDR, then increments oX and oADDR.
  - oX saturates at H_ACTIVE-1.
  - oADDR saturates at H_ACTIVE*V_ACTIVE-1.
- End of line (iBLANK_n 1→0): oX←0.
  - Internal line count increments, saturating at V_ACTIVE.
  - oY tracks the line count, clamped to V_ACTIVE-1.
- Frame reset: any cycle with iVS=0 and iHS=0 sets oX=0, oY=0, oADDR=0 and line count=0.
- oVBlank:
  - Set the cycle after line count reaches V_ACTIVE.
  - Cleared on the first iBLANK_n=1 cycle of the next frame. On that cycle the pixel is presented and oVBlank reads 0.
- oFrameStart: registered falling-edge detect of iVS, one cycle wide.
- oFrameCount: increments on oFrameStart and wraps 0xFFFF→0.
- Commit FSM (one commit per blank interval; flag `done_this_blank` is cleared when oVBlank falls):
  - IDLE: iCommitReq=1 → PENDING.
  - PENDING: oVBlank=1 and !done_this_blank → ACK. In the same edge, oState←iState and done_this_blank←1.
  - ACK: oCommitAck=1 for exactly one cycle → DONE.
  - DONE: wait for iCommitReq=0 → IDLE.
- Request during active video waits in PENDING until the next blank.
- Request deasserted while in PENDING → IDLE; no capture.
- Request arriving after this blank's commit waits for the next blank.
- iRST_n low at any point clears everything immediately, including a commit in flight. oState returns to 0.

## Timing
- oX/oY/oADDR are direct register outputs, valid in the same cycle as the iBLANK_n=1 they describe. There is zero added latency, consistent with the renderer address convention.
- oFrameStart is asserted 1 cycle after iVS falls.
- Commit latency:
  - Capture on the first edge where PENDING and oVBlank=1.
  - oCommitAck follows on the next cycle.
  - oState is stable from the capture edge through the end of the next active frame, unless the next blank commits.
- Simultaneous frame reset and iBLANK_n=1: frame reset wins.
- oVBlank set and a request arriving in the same cycle: capture occurs one cycle later.

## Configuration
- SCAN_TRACKER_FRAMECNT_EN defined: 16-bit frame counter and oFrameStart logic present.
- SCAN_TRACKER_FRAMECNT_EN undefined: oFrameCount tied to 0 and oFrameStart tied to 0. Commit FSM and counters are unchanged.

## Structure
- Package vga_scan_pkg: H_ACTIVE/V_ACTIVE defaults, ADDR_W=19, commit FSM state enum (IDLE, PENDING, ACK, DONE).
- Sub-module vga_commit_fsm: handshake FSM plus shadow register. Inputs: oVBlank and the blank-falling indication.
- Top holds the counters and edge detects.

## Test plan
- Reset mid-frame with iRST_n=0 → all outputs at reset values within the same cycle. oVBlank=1, oState=0.
- Run a full 640×480 frame → last visible pixel shows oX=639, oY=479, oADDR=307199. oVBlank=1 from the cycle after that line ends.
- Three iVS falling edges → oFrameStart pulses 3 times, one cycle each, and oFrameCount=3. With macro undefined, count stays 0.
- iCommitReq=1 with iState=0xDEADBEEF raised mid-frame → oState unchanged until blank. At blank, capture, then oCommitAck for one cycle. oState=0xDEADBEEF.
- Second request raised in the same blank after the first commit → no ack until the next blank. Request dropped in PENDING → no capture, FSM returns to IDLE.
